convolution_addr_seq: RTL and testbench

CONVOLUTION_ADDR_SEQ -- requirements
Module: convolution_addr_seq

---
 rtl/convolution_addr_seq.sv | 128 ++++++++++++
 tb/tb_convolution_addr_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/convolution_addr_seq.sv
// Address sequencer for full linear convolution Z[k] = sum_j X[j]*Y[k-j].
// Emits one (j, k-j, k) beat per term with first/last markers and a valid/ready handshake.
module convolution_addr_seq #(
  parameter int DATA_WIDTH_ADDR = 5,
  parameter int DATA_WIDTH_LEN  = DATA_WIDTH_ADDR + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [DATA_WIDTH_LEN-1:0]  lenX_i,
  input  logic [DATA_WIDTH_LEN-1:0]  lenY_i,
  input  logic                       ready_i,
  output logic [DATA_WIDTH_ADDR-1:0] addrX_o,
  output logic [DATA_WIDTH_ADDR-1:0] addrY_o,
  output logic [DATA_WIDTH_ADDR:0]   addrZ_o,
  output logic                       valid_o,
  output logic                       first_o,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int KW  = DATA_WIDTH_ADDR + 1;
  localparam int KW1 = KW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nx;
  logic [KW-1:0] len_n, len_m;
  logic [KW-1:0] n_nx, m_nx, j_nx, k_nx, y_nx;
  logic          first_nx, last_nx;
  logic          start_ok, len_zero, accept, pass_end;
  logic [KW-1:0] j_cur;

  // Lowest j contributing to output k: max(0, k-M+1); k+1 always fits in KW bits.
  function automatic logic [KW-1:0] j_low(input logic [KW-1:0] k, input logic [KW-1:0] m);
    logic [KW-1:0] kp1;
    kp1 = k + KW'(1);
    return (kp1 > m) ? (kp1 - m) : '0;
  endfunction

  function automatic logic [KW-1:0] j_high(input logic [KW-1:0] k, input logic [KW-1:0] n);
    return (k < (n - KW'(1))) ? k : (n - KW'(1));
  endfunction

  assign start_ok = (state == IDLE) && start_i;
  assign len_zero = (lenX_i == '0) || (lenY_i == '0);
  assign accept   = (state == RUN) && ready_i;
  assign j_cur    = KW'(addrX_o);
  // Compared one bit wider so N+M = 2^KW does not wrap.
  assign pass_end = ({1'b0, addrZ_o} + KW1'(2)) == ({1'b0, len_n} + {1'b0, len_m});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = len_zero ? DONE : RUN;
      RUN:     if (ready_i && last_o && pass_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    n_nx     = len_n;
    m_nx     = len_m;
    j_nx     = j_cur;
    k_nx     = addrZ_o;
    first_nx = first_o;
    last_nx  = last_o;
    if (start_ok) begin
      n_nx     = KW'(lenX_i);
      m_nx     = KW'(lenY_i);
      j_nx     = '0;
      k_nx     = '0;
      first_nx = !len_zero;
      last_nx  = !len_zero;
    end else if (accept) begin
      if (last_o) begin
        if (pass_end) begin
          first_nx = 1'b0;
          last_nx  = 1'b0;
        end else begin
          k_nx     = addrZ_o + KW'(1);
          j_nx     = j_low(k_nx, len_m);
          first_nx = 1'b1;
          last_nx  = (j_nx == j_high(k_nx, len_n));
        end
      end else begin
        j_nx     = j_cur + KW'(1);
        first_nx = 1'b0;
        last_nx  = (j_nx == j_high(addrZ_o, len_n));
      end
    end
    y_nx = k_nx - j_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_n   <= '0;
      len_m   <= '0;
      addrX_o <= '0;
      addrY_o <= '0;
      addrZ_o <= '0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      len_n   <= n_nx;
      len_m   <= m_nx;
      addrX_o <= DATA_WIDTH_ADDR'(j_nx);
      addrY_o <= DATA_WIDTH_ADDR'(y_nx);
      addrZ_o <= k_nx;
      first_o <= first_nx;
      last_o  <= last_nx;
      valid_o <= (state_nx == RUN);
      busy_o  <= (state_nx != IDLE);
      done_o  <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_convolution_addr_seq.sv
// Bench for convolution_addr_seq: randomized passes checked each cycle against a
// queue of expected (j, k-j, k) beats built from nested convolution loops.
module tb_convolution_addr_seq;
  localparam int AW = 5;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst, start_i, ready_i;
  logic [LW-1:0] lenX_i, lenY_i;
  logic [AW-1:0] addrX_o, addrY_o;
  logic [AW:0]   addrZ_o;
  logic          valid_o, first_o, last_o, busy_o, done_o;

  convolution_addr_seq #(.DATA_WIDTH_ADDR(AW), .DATA_WIDTH_LEN(LW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .lenX_i(lenX_i), .lenY_i(lenY_i),
    .ready_i(ready_i), .addrX_o(addrX_o), .addrY_o(addrY_o), .addrZ_o(addrZ_o),
    .valid_o(valid_o), .first_o(first_o), .last_o(last_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int z; bit f; bit l;} beat_t;
  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int phase = 0;  // 0 idle, 1 beats outstanding, 2 completion cycle

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected beat list straight from the convolution sum definition.
  function automatic void build(input int n, input int m);
    if (n == 0 || m == 0) return;
    for (int k = 0; k <= n + m - 2; k++) begin
      int lo, hi;
      lo = (k - m + 1 > 0) ? k - m + 1 : 0;
      hi = (k < n - 1) ? k : n - 1;
      for (int j = lo; j <= hi; j++) begin
        beat_t b;
        b.x = j; b.y = k - j; b.z = k; b.f = (j == lo); b.l = (j == hi);
        exp_q.push_back(b);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      phase = 0;
      chk("rst_valid", valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_addrz", addrZ_o, 0);
    end else begin
      chk("valid", valid_o, phase == 1);
      chk("busy", busy_o, phase != 0);
      chk("done", done_o, phase == 2);
      if (phase == 1 && exp_q.size() > 0) begin
        chk("addr_x", addrX_o, exp_q[0].x);
        chk("addr_y", addrY_o, exp_q[0].y);
        chk("addr_z", addrZ_o, exp_q[0].z);
        chk("first", first_o, exp_q[0].f);
        chk("last", last_o, exp_q[0].l);
      end
      case (phase)
        0: if (start_i) begin
          build(int'(lenX_i), int'(lenY_i));
          phase = (exp_q.size() == 0) ? 2 : 1;
        end
        1: if (ready_i) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready=1; 1: random ready/start/lengths; 2: ready=1 with start held; 3: fixed stall pattern
  task automatic run_pass(input int n, input int m, input int mode, output int cyc);
    bit seen;
    tick();
    start_i = 1'b1; lenX_i = LW'(n); lenY_i = LW'(m); ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20000) begin
      if (done_o) begin
        seen = 1'b1;
        start_i = 1'b0;
      end else begin
        case (mode)
          1: ready_i = ($urandom % 4) != 0;
          3: ready_i = !(cyc inside {1, 2, 3, 6, 7, 8});
          default: ready_i = 1'b1;
        endcase
        if (mode == 1 || mode == 2) begin
          start_i = (mode == 2) ? 1'b1 : (($urandom % 3) == 0);
          lenX_i = LW'($urandom);
          lenY_i = LW'($urandom);
        end
        tick();
        cyc++;
      end
    end
    chk("done_seen", seen, 1);
    tick();
    ready_i = 1'b0;
  endtask

  int lx[6] = '{0, 0, 1, 1, 2, 2};
  int ly[6] = '{0, 1, 0, 1, 0, 1};
  int lz[6] = '{0, 1, 1, 2, 2, 3};
  bit lf[6] = '{1, 1, 0, 1, 0, 1};
  bit ll[6] = '{1, 0, 1, 0, 1, 1};

  initial begin
    int lat;
    rst = 1'b1; start_i = 1'b0; ready_i = 1'b0; lenX_i = '0; lenY_i = '0;

    build(3, 2);
    chk("pin32_size", exp_q.size(), 6);
    for (int i = 0; i < 6 && i < exp_q.size(); i++) begin
      chk("pin32_x", exp_q[i].x, lx[i]);
      chk("pin32_y", exp_q[i].y, ly[i]);
      chk("pin32_z", exp_q[i].z, lz[i]);
      chk("pin32_f", exp_q[i].f, lf[i]);
      chk("pin32_l", exp_q[i].l, ll[i]);
    end
    exp_q.delete();
    build(32, 32);
    chk("pin_big_size", exp_q.size(), 1024);
    chk("pin_big_last", {exp_q[1023].x[7:0], exp_q[1023].y[7:0], exp_q[1023].z[7:0]},
        {8'd31, 8'd31, 8'd62});
    exp_q.delete();
    build(0, 4);
    chk("pin_zero_size", exp_q.size(), 0);
    exp_q.delete();

    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_pass(3, 2, 0, lat);
    chk("lat_3x2", lat, 6);
    run_pass(3, 2, 3, lat);
    chk("lat_3x2_stall", lat, 12);
    run_pass(1, 1, 0, lat);
    chk("lat_1x1", lat, 1);
    run_pass(0, 4, 0, lat);
    chk("lat_0x4", lat, 0);
    run_pass(32, 32, 0, lat);
    chk("lat_32x32", lat, 1024);

    // Reset in the middle of beat 3 of a 3x2 pass.
    tick();
    start_i = 1'b1; lenX_i = 3; lenY_i = 2; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("mid_beat3_x", addrX_o, 1);
    chk("mid_beat3_z", addrZ_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", valid_o, 0);
    chk("async_busy", busy_o, 0);
    chk("async_addr", {addrX_o, addrY_o, addrZ_o, first_o, last_o}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", busy_o, 0);
    run_pass(3, 2, 2, lat);
    chk("lat_after_rst", lat, 6);

    for (int t = 0; t < 20; t++) begin
      run_pass($urandom_range(0, 10), $urandom_range(0, 10), (t % 4 == 0) ? 0 : 1, lat);
    end
    run_pass($urandom_range(20, 32), $urandom_range(20, 32), 1, lat);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
